// File: rtl/read_req_queue.sv
// Row-read request queue: a small FIFO feeding a one-outstanding sequencer.
// A watchdog turns a missing read-unit response into an error response.
module read_req_queue #(
  parameter int DEPTH   = 4,
  parameter int ROW_W   = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [ROW_W-1:0]         req_row,
  output logic                     req_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [ROW_W-1:0]         rd_row,
  output logic                     rd_input_valid,
  input  logic                     rd_output_valid,
  input  logic [DATA_W-1:0]        rd_data,
  output logic                     resp_valid,
  output logic [ROW_W-1:0]         resp_row,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     resp_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state;
  logic [ROW_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] wait_cnt;
  logic             push;
  logic             pop;

  // Space freed by a same-cycle pop is only visible next cycle
  assign req_ready = occupancy != (PTR_W+1)'(DEPTH);
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (occupancy != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_row;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        occupancy <= occupancy + 1'b1;
      else if (pop && !push)
        occupancy <= occupancy - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      rd_row         <= '0;
      rd_input_valid <= 1'b0;
      resp_valid     <= 1'b0;
      resp_row       <= '0;
      resp_data      <= '0;
      resp_err       <= 1'b0;
    end else begin
      rd_input_valid <= 1'b0;
      resp_valid     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            rd_row         <= mem[rd_ptr];
            rd_input_valid <= 1'b1;
            wait_cnt       <= '0;
            state          <= WAIT;
          end
        end
        WAIT: begin
          // A real response beats a coincident timeout
          if (rd_output_valid) begin
            resp_valid <= 1'b1;
            resp_row   <= rd_row;
            resp_data  <= rd_data;
            resp_err   <= 1'b0;
            state      <= IDLE;
          end else if (wait_cnt == CNT_W'(TIMEOUT-1)) begin
            resp_valid <= 1'b1;
            resp_row   <= rd_row;
            resp_data  <= '0;
            resp_err   <= 1'b1;
            state      <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/read_req_queue.md
# read_req_queue

Request queue and sequencer placed directly upstream of the row-read unit. It buffers row-read requests from a producer in a small FIFO and issues them to the read unit one at a time as a single-cycle `input_valid` pulse with `row_num`. It then waits for the unit's `output_valid` and returns the 32-bit row contents tagged with the row number. A watchdog converts a missing response into an error response, so the queue never deadlocks.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of 2, at least 2.
- `ROW_W`, 4: row-number width.
- `DATA_W`, 32: row data width.
- `TIMEOUT`, 15: WAIT cycles allowed before an error response; at least 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  producer request strobe.
- `req_row`  in  ROW_W  requested row.
- `req_ready`  out  1  queue can accept a request this cycle.
- `occupancy`  out  $clog2(DEPTH)+1  FIFO entry count.
- `rd_row`  out  ROW_W  drives the read unit's `row_num`.
- `rd_input_valid`  out  1  drives the read unit's `input_valid`.
- `rd_output_valid`  in  1  read unit's `output_valid`.
- `rd_data`  in  DATA_W  read unit's `out`.
- `resp_valid`  out  1  response strobe, one cycle per issued request.
- `resp_row`  out  ROW_W  row of this response.
- `resp_data`  out  DATA_W  row contents; 0 on error.
- `resp_err`  out  1  response was produced by timeout.

## Operation
- Push: on each edge where `req_valid && req_ready`, `req_row` is written at the tail.
- `req_ready` = !full and is purely combinational from the registered occupancy.
  - A pop in the same cycle does not free space for that cycle's push.
- FSM states: IDLE, WAIT.
- IDLE to WAIT when the FIFO is non-empty. On that edge:
  - pop the head into `rd_row`;
  - set `rd_input_valid`=1;
  - clear the wait counter.
- WAIT:
  - `rd_input_valid` is 1 only for the first WAIT cycle, then 0.
  - `rd_row` holds its value until the next issue.
  - The wait counter increments each WAIT cycle without a response.
- Response, with `rd_output_valid`=1 sampled in any WAIT cycle, including the first:
  - set `resp_valid`=1, `resp_row`=`rd_row`, `resp_data`=`rd_data`, `resp_err`=0;
  - go to IDLE.
- Timeout, when the counter reaches TIMEOUT-1 with no response:
  - set `resp_valid`=1, `resp_err`=1, `resp_data`=0, `resp_row`=`rd_row`;
  - go to IDLE.
  - If a response and the timeout occur in the same cycle, the response wins.
- `rd_output_valid` is ignored in IDLE. This covers level-held or stray strobes from the read unit.
- Requests issue and respond strictly in FIFO order; at most one is outstanding.
- Occupancy update per edge: +1 on push only, -1 on pop only, unchanged on push and pop together. Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - `req_ready`=1, `occupancy`=0;
  - `rd_row`=0, `rd_input_valid`=0;
  - `resp_valid`=0, `resp_row`=0, `resp_data`=0, `resp_err`=0;
  - state IDLE, pointers 0, wait counter 0.
- Reset mid-operation flushes the FIFO and drops any outstanding request. A later `rd_output_valid` produces no response.
- Latency:
  - A push accepted at edge N into an empty, idle queue gives `rd_input_valid` high after edge N+1.
  - `rd_output_valid` sampled high at edge M gives `resp_valid` high after edge M.
- `resp_valid` and `rd_input_valid` are registered single-cycle pulses. `resp_row`, `resp_data` and `resp_err` hold until the next response.
- Throughput: a response at edge M is followed by the next issue at edge M+1, provided the FIFO is non-empty.
- Worst-case timeout: `resp_valid` with `resp_err`=1 comes TIMEOUT edges after the issue edge.

## Test plan
- Reset: assert `rst` between edges, not aligned to `clk`.
  - All outputs go to reset values immediately.
  - `occupancy`=0 and `req_ready`=1.
- Single read: push row 3; the read-unit model returns 32'd300 two cycles after `input_valid`.
  - `rd_input_valid` is high exactly one cycle, with `rd_row`=3.
  - One `resp_valid` with `resp_row`=3, `resp_data`=300, `resp_err`=0.
- Full queue: stall the read model and push rows 1..6 on consecutive cycles.
  - Row 1 issues; rows 2..5 fill the FIFO; `occupancy`=4 and `req_ready`=0.
  - Row 6 is held until a pop.
  - Releasing the model yields responses in order 1..6.
- Timeout: the model never answers row 7.
  - 15 edges after issue: `resp_valid`=1, `resp_err`=1, `resp_row`=7, `resp_data`=0.
  - The next queued row issues on the following edge.
- Stray strobe: drive `rd_output_valid`=1 while the queue is empty and IDLE.
  - No `resp_valid` is produced.
- Reset in WAIT: issue row 8, assert `rst` two cycles later, then deliver `rd_output_valid`.
  - No `resp_valid` is produced.
  - `rd_input_valid` stays 0 and the queue is empty.
